// File: rtl/predictor_table_ctrl_if.sv
// predictor_table_ctrl_if
//   Pipeline-facing bundle of the predictor table controller.
//   master : fetch/resolve side (drives lookup and update requests)
//   slave  : controller side (returns ready flags and the prediction)
//   lk_valid/lk_addr/lk_ready       lookup request handshake
//   pred_valid/pred_taken           prediction response, one-cycle pulse
//   up_valid/up_addr/up_taken/up_ready  resolved-branch update handshake
interface predictor_table_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              lk_valid;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_ready;
  logic              pred_valid;
  logic              pred_taken;
  logic              up_valid;
  logic [ADDR_W-1:0] up_addr;
  logic              up_taken;
  logic              up_ready;

  modport master (
    output lk_valid, lk_addr, up_valid, up_addr, up_taken,
    input  lk_ready, pred_valid, pred_taken, up_ready
  );

  modport slave (
    input  lk_valid, lk_addr, up_valid, up_addr, up_taken,
    output lk_ready, pred_valid, pred_taken, up_ready
  );
endinterface

// File: rtl/predictor_table_ctrl.sv
// predictor_table_ctrl
//   Sequencer for the 2-bit predictor table. Sweeps every entry to
//   weakly-not-taken after reset (or init_req), then shares the single
//   table slot per cycle between lookups and FIFO-buffered updates.
//   Lookups win unless the update FIFO is full or the pending update
//   has been passed over MAX_STARVE times in a row.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   init_req_i           restart sweep (honoured only in RUN)
//   init_done_o          sweep complete, block in RUN
//   bus                  lookup / prediction / update handshakes
//   uq_count_o           update FIFO occupancy
//   tbl_*_o              registered table access strobes, index, outcome
//   tbl_prediction_i     table read data for the tbl_request_o cycle
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | one tbl_init per cycle, index 0..2^ADDR_W-1; no handshakes
// ST_RUN  | arbitrate lookups vs. queued updates, one table op per cycle
module predictor_table_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int UQ_DEPTH   = 4,
  parameter int MAX_STARVE = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      init_req_i,
  output logic                      init_done_o,
  predictor_table_ctrl_if.slave     bus,
  output logic [$clog2(UQ_DEPTH):0] uq_count_o,
  output logic [ADDR_W-1:0]         tbl_addr_o,
  output logic                      tbl_request_o,
  output logic                      tbl_result_o,
  output logic                      tbl_taken_o,
  output logic                      tbl_init_o,
  input  logic                      tbl_prediction_i
);

  localparam int PTR_W = $clog2(UQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(UQ_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [SW-1:0]     STARVE_ONE = SW'(1);
  localparam logic [ADDR_W:0]   SWEEP_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  // Extra MSB marks "all indices issued" so the last strobe needs no compare.
  logic [ADDR_W:0]   sweep_q, sweep_d;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic [ADDR_W-1:0] fifo_addr  [UQ_DEPTH];
  logic              fifo_taken [UQ_DEPTH];

  logic [ADDR_W-1:0] tbl_addr_q, tbl_addr_d;
  logic              tbl_req_q, tbl_req_d;
  logic              tbl_res_q, tbl_res_d;
  logic              tbl_taken_q, tbl_taken_d;
  logic              tbl_init_q, tbl_init_d;
  logic              pred_valid_q, pred_taken_q;

  logic lk_ready, up_ready, grant_lk, pop, push, full, empty;

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    lk_ready    = 1'b0;
    up_ready    = 1'b0;
    grant_lk    = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    full        = (cnt_q == CNT_FULL);
    empty       = (cnt_q == '0);
    tbl_addr_d  = '0;
    tbl_req_d   = 1'b0;
    tbl_res_d   = 1'b0;
    tbl_taken_d = 1'b0;
    tbl_init_d  = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (sweep_q[ADDR_W]) begin
          state_d = ST_RUN;
        end else begin
          tbl_init_d = 1'b1;
          tbl_addr_d = sweep_q[ADDR_W-1:0];
          sweep_d    = sweep_q + SWEEP_ONE;
        end
      end
      ST_RUN: begin
        if (init_req_i) begin
          // No grants in the restart cycle; queued updates are dropped.
          state_d  = ST_INIT;
          sweep_d  = '0;
          wr_d     = '0;
          rd_d     = '0;
          cnt_d    = '0;
          starve_d = '0;
        end else begin
          up_ready = !full;
          lk_ready = !(full || (starve_q == STARVE_MAX));
          grant_lk = lk_ready && bus.lk_valid;
          // Any cycle without a granted lookup goes to a pending update.
          pop      = !grant_lk && !empty;
          push     = bus.up_valid && up_ready;

          if (grant_lk) begin
            tbl_req_d  = 1'b1;
            tbl_addr_d = bus.lk_addr;
          end else if (pop) begin
            tbl_res_d   = 1'b1;
            tbl_addr_d  = fifo_addr[rd_q];
            tbl_taken_d = fifo_taken[rd_q];
          end

          if (pop)  rd_d = rd_q + PTR_ONE;
          if (push) wr_d = wr_q + PTR_ONE;
          case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
          endcase

          if (pop || empty)
            starve_d = '0;
          else if (grant_lk && (starve_q != STARVE_MAX))
            starve_d = starve_q + STARVE_ONE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      starve_q     <= '0;
      tbl_addr_q   <= '0;
      tbl_req_q    <= 1'b0;
      tbl_res_q    <= 1'b0;
      tbl_taken_q  <= 1'b0;
      tbl_init_q   <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      tbl_addr_q   <= tbl_addr_d;
      tbl_req_q    <= tbl_req_d;
      tbl_res_q    <= tbl_res_d;
      tbl_taken_q  <= tbl_taken_d;
      tbl_init_q   <= tbl_init_d;
      // Response is independent of state so in-flight lookups survive init_req.
      pred_valid_q <= tbl_req_q;
      pred_taken_q <= tbl_req_q & tbl_prediction_i;
    end
  end

  // Storage only; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_q]  <= bus.up_addr;
      fifo_taken[wr_q] <= bus.up_taken;
    end
  end

  assign init_done_o    = (state_q == ST_RUN);
  assign uq_count_o     = cnt_q;
  assign tbl_addr_o     = tbl_addr_q;
  assign tbl_request_o  = tbl_req_q;
  assign tbl_result_o   = tbl_res_q;
  assign tbl_taken_o    = tbl_taken_q;
  assign tbl_init_o     = tbl_init_q;
  assign bus.lk_ready   = lk_ready;
  assign bus.up_ready   = up_ready;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;

endmodule

// File: doc/predictor_table_ctrl.md
Name: predictor_table_ctrl

Overview:
Front-end sequencer for the 256-entry 2-bit predictor table. It sweeps the table to a known state after reset, then shares the single table access slot per cycle between fetch-stage lookups and branch-resolve updates. Updates are buffered in a small FIFO. Lookups win arbitration, subject to a starvation bound. It sits between the fetch/resolve pipeline stages and the table instance.

Parameters:
ADDR_W, 8, table index width (table holds 1<<ADDR_W entries)
UQ_DEPTH, 4, update FIFO depth (power of two, >=2)
MAX_STARVE, 3, max consecutive granted lookups while an update is pending

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous, active-low reset
init_req  in  1  pulse: restart table sweep (ignored while sweep running)
init_done  out  1  high when sweep complete and block in RUN
lk_valid  in  1  lookup request
lk_addr  in  ADDR_W  lookup index
lk_ready  out  1  lookup accepted when lk_valid&lk_ready
pred_valid  out  1  prediction response valid (one-cycle pulse)
pred_taken  out  1  predicted direction
up_valid  in  1  update request
up_addr  in  ADDR_W  update index
up_taken  in  1  resolved outcome
up_ready  out  1  update FIFO not full
uq_count  out  $clog2(UQ_DEPTH)+1  FIFO occupancy
tbl_addr  out  ADDR_W  table index (registered)
tbl_request  out  1  table lookup strobe (registered)
tbl_result  out  1  table update strobe (registered)
tbl_taken  out  1  update outcome (registered)
tbl_init  out  1  table entry init strobe: set entry to weakly-not-taken (registered)
tbl_prediction  in  1  table read data, combinational from tbl_addr in the tbl_request cycle

Behaviour:
- Reset (rst_n low, async): state=INIT, sweep index=0, FIFO empty, starvation counter=0. All outputs 0 except uq_count=0. lk_ready and up_ready are also 0.
- States: INIT -> RUN -> INIT.
  - INIT -> RUN after the sweep ends.
  - RUN -> INIT on init_req.
- INIT:
  - One tbl_init per cycle, tbl_addr=0..(1<<ADDR_W)-1 ascending. The first strobe is in the first clock after reset release.
  - After the last index: next cycle state=RUN, init_done=1.
  - A full sweep takes exactly 256 strobe cycles at default.
  - lk_ready=0 and up_ready=0 throughout.
  - init_req in RUN: FIFO is flushed (queued updates discarded), init_done drops next cycle, sweep restarts at 0.
  - An in-flight lookup whose response cycle falls after init_req still produces its pred_valid.
- RUN, per cycle at most one table operation.
  - Lookup accepted in cycle N: tbl_request=1, tbl_addr=lk_addr in N+1. pred_taken is registered from tbl_prediction, so pred_valid=1 in N+2. Latency is 2 and fully pipelined: back-to-back lookups give back-to-back responses.
  - Update accepted into the FIFO when up_valid&up_ready. up_ready = (count < UQ_DEPTH), combinational, and 0 outside RUN.
  - FIFO pop (arbitration grant to update): tbl_result=1, tbl_addr/tbl_taken = head entry in the following cycle.
- Arbitration, evaluated each RUN cycle:
  - FIFO full, or starve counter == MAX_STARVE: update wins, lk_ready=0.
  - Otherwise lk_ready=1. If lk_valid, lookup wins; else pop if FIFO non-empty.
- Starve counter:
  - Increments on each granted lookup while FIFO is non-empty.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at MAX_STARVE.
- Push and pop in the same cycle: count unchanged. A push into a full FIFO cannot occur because up_ready=0, even if a pop happens that cycle.
- FIFO pointers wrap modulo UQ_DEPTH; count range 0..UQ_DEPTH.
- No forwarding: a lookup to an address with a queued update reads the stale table value. Ordering between updates is strictly FIFO.
- tbl_request, tbl_result and tbl_init are mutually exclusive every cycle.

Test Plan:
- Reset release, no traffic -> tbl_init strobes addr 0..255 over 256 consecutive cycles, then init_done=1 and lk_ready=1. No tbl_request/tbl_result during the sweep.
- RUN, lookup addr 0x2A in cycle N with tbl_prediction=1 -> tbl_request=1, tbl_addr=0x2A in N+1; pred_valid=1, pred_taken=1 in N+2. Four back-to-back lookups -> four consecutive pred_valid pulses.
- Updates to 0x10 (taken=1) and 0x11 (taken=0), no lookups -> tbl_result pulses for 0x10 then 0x11 in order, tbl_taken 1 then 0; uq_count returns to 0.
- Continuous lk_valid with one queued update, MAX_STARVE=3 -> three lookups granted, then lk_ready=0 for one cycle and the update is issued; lookups resume after.
- Fill FIFO with 4 updates while lk_valid is held -> up_ready=0 and lk_ready=0 at count=4; a pop issues next cycle; simultaneous push+pop at count=3 keeps count=3.
- init_req in RUN with 2 queued updates -> uq_count=0 and init_done=0 next cycle, sweep restarts at addr 0, queued updates are never issued. Asserting rst_n low mid-sweep -> all outputs 0 immediately, and the sweep restarts at 0 after release.
